fractcam_wr_ctrl: RTL and testbench

- Update sequencer and access arbiter for one FracTCAM block: SLICEM LUTRAM columns of 2^SLICE_WIDTH x 1 bits, one column per key slice per entry, whose match bits are AND-reduced per entry.
- Converts an entry write (index, key, care-mask) into a 2^SLICE_WIDTH-cycle sweep of LUTRAM write address/data/enable.
- Holds off searches while a sweep is in progress.
- Sits between the control-plane table manager and the FracTCAM array/AND-tree datapath.

---
 rtl/fractcam_pkg.sv | 19 +
 rtl/fractcam_slice_gen.sv | 21 ++
 rtl/fractcam_wr_ctrl.sv | 117 +++++++++++
 tb/tb_fractcam_wr_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fractcam_pkg.sv
// Shared types and sizing helpers for the FracTCAM write controller.
// Slices are padded up to a whole number of LUTRAM columns.
package fractcam_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  function automatic int calc_num_slice(input int key_width, input int slice_width);
    return (key_width + slice_width - 1) / slice_width;
  endfunction

  function automatic int calc_pad_width(input int key_width, input int slice_width);
    return calc_num_slice(key_width, slice_width) * slice_width;
  endfunction

  localparam int DEF_KEY_WIDTH   = 40;
  localparam int DEF_SLICE_WIDTH = 5;
  localparam int DEF_PAD_WIDTH   = calc_pad_width(DEF_KEY_WIDTH, DEF_SLICE_WIDTH);

endpackage

// File: rtl/fractcam_slice_gen.sv
// Per-column LUTRAM write bit: a column stores 1 at every address that
// matches its key slice on all cared-about bits.
module fractcam_slice_gen #(
  parameter int SLICE_WIDTH = 5,
  parameter int NUM_SLICE   = 8
) (
  input  logic [SLICE_WIDTH-1:0]           addr,
  input  logic [NUM_SLICE*SLICE_WIDTH-1:0] key,
  input  logic [NUM_SLICE*SLICE_WIDTH-1:0] mask,
  output logic [NUM_SLICE-1:0]             match
);

  always_comb begin
    match = '0;
    for (int s = 0; s < NUM_SLICE; s++) begin
      match[s] = ((addr ^ key[s*SLICE_WIDTH +: SLICE_WIDTH]) &
                  mask[s*SLICE_WIDTH +: SLICE_WIDTH]) == '0;
    end
  end

endmodule

// File: rtl/fractcam_wr_ctrl.sv
// FracTCAM update sequencer: sweeps every LUTRAM address for one entry and
// holds off searches meanwhile. Optional FRACTCAM_ENTRY_VALID_EN adds m_entry_valid.
module fractcam_wr_ctrl
  import fractcam_pkg::*;
#(
  parameter int KEY_WIDTH   = 40,
  parameter int SLICE_WIDTH = 5,
  parameter int DEPTH       = 64,
  parameter int IDX_WIDTH   = $clog2(DEPTH),
  parameter int NUM_SLICE   = calc_num_slice(KEY_WIDTH, SLICE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_WIDTH-1:0]   s_wr_idx,
  input  logic [KEY_WIDTH-1:0]   s_wr_key,
  input  logic [KEY_WIDTH-1:0]   s_wr_mask,
  input  logic                   s_wr_install,
  input  logic                   s_wr_valid,
  output logic                   s_wr_ready,
  output logic                   m_wr_done,
  output logic [SLICE_WIDTH-1:0] m_lut_addr,
  output logic [NUM_SLICE-1:0]   m_lut_wdata,
  output logic [DEPTH-1:0]       m_lut_we,
  input  logic [KEY_WIDTH-1:0]   s_search_key,
  input  logic                   s_search_valid,
  output logic                   s_search_ready,
  output logic [KEY_WIDTH-1:0]   m_search_key,
  output logic                   m_search_valid,
`ifdef FRACTCAM_ENTRY_VALID_EN
  output logic [DEPTH-1:0]       m_entry_valid,
`endif
  output logic                   busy
);

  localparam int PAD_WIDTH = NUM_SLICE * SLICE_WIDTH;

  state_t                 state;
  logic [SLICE_WIDTH-1:0] addr;
  logic [IDX_WIDTH-1:0]   idx_r;
  logic [PAD_WIDTH-1:0]   key_r;
  logic [PAD_WIDTH-1:0]   mask_r;
  logic                   install_r;
  logic [NUM_SLICE-1:0]   slice_match;

  // Zero-extension pads the last slice: key 0 and mask 0 (don't care) there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      idx_r          <= '0;
      key_r          <= '0;
      mask_r         <= '0;
      install_r      <= 1'b0;
      m_search_key   <= '0;
      m_search_valid <= 1'b0;
`ifdef FRACTCAM_ENTRY_VALID_EN
      m_entry_valid  <= '0;
`endif
    end else begin
      m_search_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_wr_valid) begin
            idx_r     <= s_wr_idx;
            key_r     <= PAD_WIDTH'(s_wr_key);
            mask_r    <= PAD_WIDTH'(s_wr_mask);
            install_r <= s_wr_install;
            addr      <= '0;
            state     <= SWEEP;
          end else if (s_search_valid) begin
            m_search_key   <= s_search_key;
            m_search_valid <= 1'b1;
          end
        end
        SWEEP: begin
          addr <= addr + 1'b1;
          if (addr == '1) state <= DONE;
        end
        DONE: begin
`ifdef FRACTCAM_ENTRY_VALID_EN
          for (int i = 0; i < DEPTH; i++) begin
            if (idx_r == IDX_WIDTH'(i)) m_entry_valid[i] <= install_r;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fractcam_slice_gen #(
    .SLICE_WIDTH(SLICE_WIDTH),
    .NUM_SLICE  (NUM_SLICE)
  ) u_slice_gen (
    .addr (addr),
    .key  (key_r),
    .mask (mask_r),
    .match(slice_match)
  );

  // Out-of-range indices match no row, so the sweep runs as a dropped write.
  always_comb begin
    m_lut_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state == SWEEP && idx_r == IDX_WIDTH'(i)) m_lut_we[i] = 1'b1;
    end
  end

  assign m_lut_wdata    = (state == SWEEP && install_r) ? slice_match : '0;
  assign m_lut_addr     = addr;
  assign busy           = (state != IDLE);
  assign m_wr_done      = (state == DONE);
  assign s_wr_ready     = (state == IDLE);
  assign s_search_ready = (state == IDLE) && !s_wr_valid;

endmodule

// File: tb/tb_fractcam_wr_ctrl.sv
// Directed bench for fractcam_wr_ctrl: table of entry writes plus hand-written
// collision, reset-mid-sweep and 41-bit key sequences.
module tb_fractcam_wr_ctrl;

  localparam int KW = 40, SW = 5, DEPTH = 64, IW = 6, NS = 8;
  localparam int KW41 = 41, NS41 = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [IW-1:0]    wr_idx;
  logic [KW-1:0]    wr_key, wr_mask, search_key;
  logic             wr_install, wr_valid, search_valid;
  logic             s_wr_ready, m_wr_done, s_search_ready, m_search_valid, busy;
  logic [SW-1:0]    m_lut_addr;
  logic [NS-1:0]    m_lut_wdata;
  logic [DEPTH-1:0] m_lut_we;
  logic [KW-1:0]    m_search_key;
`ifdef FRACTCAM_ENTRY_VALID_EN
  logic [DEPTH-1:0] m_entry_valid, ev41;
`endif

  logic [IW-1:0]    w41_idx;
  logic [KW41-1:0]  w41_key, w41_mask, s41_key, m41_search_key;
  logic             w41_install, w41_valid, s41_valid;
  logic             w41_ready, done41, s41_ready, m41_search_valid, busy41;
  logic [SW-1:0]    addr41;
  logic [NS41-1:0]  wdata41;
  logic [DEPTH-1:0] we41;

  fractcam_wr_ctrl #(.KEY_WIDTH(KW), .SLICE_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_wr_idx(wr_idx), .s_wr_key(wr_key), .s_wr_mask(wr_mask),
    .s_wr_install(wr_install), .s_wr_valid(wr_valid), .s_wr_ready(s_wr_ready),
    .m_wr_done(m_wr_done), .m_lut_addr(m_lut_addr), .m_lut_wdata(m_lut_wdata),
    .m_lut_we(m_lut_we), .s_search_key(search_key), .s_search_valid(search_valid),
    .s_search_ready(s_search_ready), .m_search_key(m_search_key),
    .m_search_valid(m_search_valid),
`ifdef FRACTCAM_ENTRY_VALID_EN
    .m_entry_valid(m_entry_valid),
`endif
    .busy(busy)
  );

  fractcam_wr_ctrl #(.KEY_WIDTH(KW41), .SLICE_WIDTH(SW), .DEPTH(DEPTH)) dut41 (
    .clk(clk), .rst(rst),
    .s_wr_idx(w41_idx), .s_wr_key(w41_key), .s_wr_mask(w41_mask),
    .s_wr_install(w41_install), .s_wr_valid(w41_valid), .s_wr_ready(w41_ready),
    .m_wr_done(done41), .m_lut_addr(addr41), .m_lut_wdata(wdata41),
    .m_lut_we(we41), .s_search_key(s41_key), .s_search_valid(s41_valid),
    .s_search_ready(s41_ready), .m_search_key(m41_search_key),
    .m_search_valid(m41_search_valid),
`ifdef FRACTCAM_ENTRY_VALID_EN
    .m_entry_valid(ev41),
`endif
    .busy(busy41)
  );

  typedef struct {
    logic [IW-1:0]    idx;
    logic [KW-1:0]    key;
    logic [KW-1:0]    mask;
    logic             install;
    logic [DEPTH-1:0] exp_we;
    int               exp_ones;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slice s holds 1 at address a iff every cared-about key bit equals the address bit.
  function automatic logic [NS-1:0] modelBits(input logic [KW-1:0] key, input logic [KW-1:0] mask,
                                              input logic install, input logic [SW-1:0] a);
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) begin
      r[s] = install;
      for (int b = 0; b < SW; b++)
        if (mask[s*SW+b] && (a[b] != key[s*SW+b])) r[s] = 1'b0;
    end
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int ones;
    ones = 0;
    @(negedge clk);
    checkOutput("idle_wr_ready", 64'(s_wr_ready), 64'd1);
    wr_idx = v.idx; wr_key = v.key; wr_mask = v.mask; wr_install = v.install; wr_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) begin
        wr_valid = 1'b0;
        wr_key = ~v.key;
      end
      checkOutput("sweep_busy", 64'(busy), 64'd1);
      checkOutput("sweep_addr", 64'(m_lut_addr), 64'(i));
      checkOutput("sweep_we", m_lut_we, v.exp_we);
      checkOutput("sweep_wdata", 64'(m_lut_wdata), 64'(modelBits(v.key, v.mask, v.install, 5'(i))));
      checkOutput("sweep_wr_ready", 64'(s_wr_ready), 64'd0);
      checkOutput("sweep_done", 64'(m_wr_done), 64'd0);
      ones += $countones(m_lut_wdata);
    end
    checkOutput("sweep_ones", 64'(ones), 64'(v.exp_ones));
    @(negedge clk);
    checkOutput("done_pulse", 64'(m_wr_done), 64'd1);
    checkOutput("done_we", m_lut_we, 64'd0);
    checkOutput("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("post_done", 64'(m_wr_done), 64'd0);
    checkOutput("post_busy", 64'(busy), 64'd0);
    checkOutput("post_wr_ready", 64'(s_wr_ready), 64'd1);
`ifdef FRACTCAM_ENTRY_VALID_EN
    checkOutput("entry_valid", 64'(m_entry_valid[v.idx]), 64'(v.install));
`endif
  endtask

  initial begin
    int low_cnt, guard, cnt41;
    vecs[0] = '{6'd3,  40'h12_3456_789A, 40'hFF_FFFF_FFFF, 1'b1, 64'h8, 8};
    vecs[1] = '{6'd3,  40'h12_3456_789A, 40'hFF_FFFF_FFE0, 1'b1, 64'h8, 39};
    vecs[2] = '{6'd63, 40'h00_0000_0000, 40'h00_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 256};
    vecs[3] = '{6'd63, 40'h12_3456_789A, 40'hFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 0};
    vecs[4] = '{6'd0,  40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 64'h1, 8};

    rst = 1'b1;
    wr_idx = '0; wr_key = '0; wr_mask = '0; wr_install = 1'b0; wr_valid = 1'b0;
    search_key = '0; search_valid = 1'b0;
    w41_idx = '0; w41_key = '0; w41_mask = '0; w41_install = 1'b0; w41_valid = 1'b0;
    s41_key = '0; s41_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_ready", 64'(s_wr_ready), 64'd1);
    checkOutput("rst_search_ready", 64'(s_search_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_we", m_lut_we, 64'd0);
    checkOutput("rst_wdata", 64'(m_lut_wdata), 64'd0);
    checkOutput("rst_done", 64'(m_wr_done), 64'd0);
    checkOutput("rst_search_valid", 64'(m_search_valid), 64'd0);
    checkOutput("rst_addr", 64'(m_lut_addr), 64'd0);

    for (int n = 0; n < 5; n++) applyStimulus(vecs[n]);

    // Write and search collide: write wins, search waits out the sweep.
    @(negedge clk);
    wr_idx = 6'd5; wr_key = 40'hAB_CDEF_0123; wr_mask = '1; wr_install = 1'b1; wr_valid = 1'b1;
    search_key = 40'h55_AA55_AA55; search_valid = 1'b1;
    #1;
    checkOutput("collide_search_ready", 64'(s_search_ready), 64'd0);
    checkOutput("collide_wr_ready", 64'(s_wr_ready), 64'd1);
    low_cnt = 1;
    guard = 0;
    @(negedge clk);
    wr_valid = 1'b0;
    while (s_search_ready == 1'b0 && guard < 60) begin
      checkOutput("stall_search_valid", 64'(m_search_valid), 64'd0);
      low_cnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("stall_len", 64'(low_cnt), 64'd34);
    checkOutput("idle_search_valid", 64'(m_search_valid), 64'd0);
    @(negedge clk);
    checkOutput("search_valid", 64'(m_search_valid), 64'd1);
    checkOutput("search_key", 64'(m_search_key), 64'h55_AA55_AA55);
    search_valid = 1'b0;
    @(negedge clk);
    checkOutput("search_valid_drop", 64'(m_search_valid), 64'd0);

    // Reset in the middle of a sweep.
    wr_idx = 6'd7; wr_key = '0; wr_mask = '0; wr_install = 1'b1; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    guard = 0;
    while (m_lut_addr != 5'd10 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_addr10", 64'(m_lut_addr), 64'd10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_we", m_lut_we, 64'd0);
    checkOutput("midrst_done", 64'(m_wr_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_busy", 64'(busy), 64'd0);
    checkOutput("postrst_addr", 64'(m_lut_addr), 64'd0);
    applyStimulus(vecs[0]);

    // 41-bit key: slice 8 cares about bit 40 only, so it matches odd addresses.
    @(negedge clk);
    w41_idx = 6'd1; w41_key = 41'h100_0000_0000; w41_mask = '1; w41_install = 1'b1; w41_valid = 1'b1;
    cnt41 = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w41_valid = 1'b0;
      checkOutput("k41_addr", 64'(addr41), 64'(i));
      checkOutput("k41_slice8", 64'(wdata41[8]), 64'(i % 2));
      cnt41 += int'(wdata41[8]);
    end
    checkOutput("k41_count", 64'(cnt41), 64'd16);
    @(negedge clk);
    checkOutput("k41_done", 64'(done41), 64'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
